// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor (master) and the PLL/system side (slave).
interface pll_lock_supervisor_if;
    logic       lock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked_ok;
    logic [2:0] state;
    logic [7:0] relock_cnt;
    logic       pll_fail;

    modport master (
        input  lock,
        output pll_reset, sys_rst_n, locked_ok, state, relock_cnt, pll_fail
    );

    modport slave (
        output lock,
        input  pll_reset, sys_rst_n, locked_ok, state, relock_cnt, pll_fail
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases system reset.
// Optional macro LOCK_RETRY_LIMIT_EN: give up in FAIL after MAX_RETRY consecutive lock timeouts.
module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int LOCK_STABLE     = 1024,
    parameter int MAX_RETRY       = 4
) (
    input  logic                     clkin,
    input  logic                     reset_n,
    pll_lock_supervisor_if.master    sup
);
    localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (LOCK_STABLE > MAX_RETRY) ? LOCK_STABLE : MAX_RETRY;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    logic             lock_meta_reg;
    logic             lock_s_reg;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       relock_reg, relock_next;
    logic             pll_reset_reg;
    logic             sys_rst_n_reg;
    logic             locked_ok_reg;

`ifdef LOCK_RETRY_LIMIT_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic               pll_fail_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 1'b1;
        relock_next = relock_reg;
`ifdef LOCK_RETRY_LIMIT_EN
        retry_next  = retry_reg;
`endif
        case (state_reg)
            ST_RESET_PLL: begin
                if (cnt_reg == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested before the timeout so a simultaneous lock wins.
                if (lock_s_reg) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_next = '0;
`ifdef LOCK_RETRY_LIMIT_EN
                    if (retry_reg == RETRY_W'(MAX_RETRY - 1)) begin
                        state_next = ST_FAIL;
                    end else begin
                        state_next = ST_RESET_PLL;
                        retry_next = retry_reg + 1'b1;
                    end
`else
                    state_next = ST_RESET_PLL;
`endif
                end
            end
            ST_STABLE: begin
                if (!lock_s_reg) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(LOCK_STABLE - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
`ifdef LOCK_RETRY_LIMIT_EN
                    retry_next = '0;
`endif
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (!lock_s_reg) begin
                    state_next = ST_RESET_PLL;
                    if (relock_reg != 8'hFF) begin
                        relock_next = relock_reg + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_RESET_PLL;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
            state_reg     <= ST_RESET_PLL;
            cnt_reg       <= '0;
            relock_reg    <= 8'd0;
            pll_reset_reg <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            locked_ok_reg <= 1'b0;
        end else begin
            lock_meta_reg <= sup.lock;
            lock_s_reg    <= lock_meta_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            relock_reg    <= relock_next;
            pll_reset_reg <= (state_next == ST_RESET_PLL) || (state_next == ST_FAIL);
            sys_rst_n_reg <= (state_next == ST_RUN);
            locked_ok_reg <= (state_next == ST_RUN);
        end
    end

`ifdef LOCK_RETRY_LIMIT_EN
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            retry_reg    <= '0;
            pll_fail_reg <= 1'b0;
        end else begin
            retry_reg    <= retry_next;
            pll_fail_reg <= (state_next == ST_FAIL);
        end
    end
    assign sup.pll_fail = pll_fail_reg;
`else
    assign sup.pll_fail = 1'b0;
`endif

    assign sup.pll_reset  = pll_reset_reg;
    assign sup.sys_rst_n  = sys_rst_n_reg;
    assign sup.locked_ok  = locked_ok_reg;
    assign sup.state      = state_reg;
    assign sup.relock_cnt = relock_reg;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRY=2).
module tb_pll_lock_supervisor;
`ifdef LOCK_RETRY_LIMIT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clkin   = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pll_lock_supervisor_if sup_if ();

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES (4),
        .LOCK_TIMEOUT    (20),
        .LOCK_STABLE     (8),
        .MAX_RETRY       (2)
    ) dut (
        .clkin   (clkin),
        .reset_n (reset_n),
        .sup     (sup_if.master)
    );

    always #5 clkin = ~clkin;

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] st, input logic pr,
                             input logic sr, input logic lk, input logic pf);
        check({tag, ".state"},     {29'd0, sup_if.state},     {29'd0, st});
        check({tag, ".pll_reset"}, {31'd0, sup_if.pll_reset}, {31'd0, pr});
        check({tag, ".sys_rst_n"}, {31'd0, sup_if.sys_rst_n}, {31'd0, sr});
        check({tag, ".locked_ok"}, {31'd0, sup_if.locked_ok}, {31'd0, lk});
        check({tag, ".pll_fail"},  {31'd0, sup_if.pll_fail},  {31'd0, pf});
    endtask

    task automatic check_reset_values(input string tag);
        check_out(tag, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, ".relock_cnt"}, {24'd0, sup_if.relock_cnt}, 32'd0);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (sup_if.state !== st && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, ".reached"}, {29'd0, sup_if.state}, {29'd0, st});
    endtask

    initial begin
        int exp_relock;
        sup_if.lock = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1 check_reset_values("por");
        tick(2);
        check_reset_values("por_hold");
        reset_n = 1'b1;
        $display("step: reset released");

        // First PLL reset pulse lasts exactly 4 cycles.
        tick(3);
        check_out("hold_last", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("wait_entry", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock rises 10 cycles after release; 2-flop sync then one decision edge.
        tick(6);
        sup_if.lock = 1'b1;
        tick(2);
        check_out("sync_delay", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("stable_entry", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(7);
        check_out("stable_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("run_entry", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("step: first lock reached RUN");

        // Loss of lock in RUN: reaction on the third edge after the drop.
        sup_if.lock = 1'b0;
        tick(2);
        check_out("run_loss_sync", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("run_loss", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("relock_first", {24'd0, sup_if.relock_cnt}, 32'd1);

        // Repeated relocks saturate the counter at 255.
        for (int i = 2; i <= 300; i++) begin
            sup_if.lock = 1'b1;
            wait_state("relock_run", 3'd3, 64);
            sup_if.lock = 1'b0;
            wait_state("relock_rst", 3'd0, 16);
            exp_relock = (i > 255) ? 255 : i;
            check("relock_cnt", {24'd0, sup_if.relock_cnt}, exp_relock);
            $display("relock round %0d relock_cnt=%0d", i, sup_if.relock_cnt);
        end

        // One-cycle lock dropout at stable count 5 sends STABLE back to WAIT_LOCK.
        sup_if.lock = 1'b1;
        wait_state("glitch_stable", 3'd2, 32);
        tick(3);
        sup_if.lock = 1'b0;
        tick(1);
        sup_if.lock = 1'b1;
        tick(1);
        check_out("glitch_pre", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("glitch_back", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("glitch_restable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(7);
        check_out("glitch_stable_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("glitch_run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("step: STABLE dropout recovered");

        // Lock seen on the 20th WAIT_LOCK cycle wins over the timeout.
        sup_if.lock = 1'b0;
        wait_state("edge_rst", 3'd0, 8);
        tick(4);
        check_out("edge_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(17);
        sup_if.lock = 1'b1;
        tick(2);
        check_out("edge_wait_late", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("edge_lock_wins", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock lost in STABLE, then held low: timeouts every 24 cycles.
        sup_if.lock = 1'b0;
        tick(3);
        check_out("stable_loss", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(19);
        check_out("to1_last_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("to1_retry", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        check_out("to1_pulse_last", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("to1_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(19);
        check_out("to2_last_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        if (RETRY_EN) begin
            check_out("to2_fail", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
            sup_if.lock = 1'b1;
            tick(6);
            check_out("fail_ignores_lock", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
            check_out("to2_retry", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        $display("step: timeout sequence done");

        // Asynchronous reset between clock edges, mid-FAIL (or mid-retry).
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_mid_fail");
        tick(1);
        sup_if.lock = 1'b1;
        reset_n = 1'b1;

        // Asynchronous reset in the middle of STABLE.
        wait_state("async_stable", 3'd2, 32);
        tick(2);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_mid_stable");
        tick(1);
        reset_n = 1'b1;
        $display("step: async reset checks done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
